// File: rtl/sensor_scheduler.sv
// Round-robin trigger/timeout scheduler for an HC-SR04 and a DHT11 sensor.
// Define SCHED_ERRCNT_EN to add saturating per-channel error counters.
module sensor_scheduler #(
   parameter int CLK_HZ         = 100_000_000,
   parameter int SR04_PERIOD_MS = 100,
   parameter int DHT_PERIOD_MS  = 2000,
   parameter int SR04_TMO_MS    = 50,
   parameter int DHT_TMO_MS     = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       btn_req,
   output logic       sr04_start,
   input  logic       sr04_done,
   input  logic [8:0] sr04_dist,
   output logic       dht_start,
   input  logic       dht_done,
   input  logic       dht_valid,
   input  logic [7:0] dht_hum,
   input  logic [7:0] dht_temp,
   output logic [8:0] dist_q,
   output logic [7:0] hum_q,
   output logic [7:0] temp_q,
   output logic       busy,
   output logic       err_sr04,
   output logic       err_dht,
`ifdef SCHED_ERRCNT_EN
   output logic [7:0] err_cnt_sr04,
   output logic [7:0] err_cnt_dht,
`endif
   output logic [2:0] state
);

   localparam int DIV = CLK_HZ / 1000;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SR04_START = 3'd1,
      SR04_WAIT  = 3'd2,
      DHT_START  = 3'd3,
      DHT_WAIT   = 3'd4
   } state_t;

   state_t        cur, nxt;
   logic [PW-1:0] pre;
   logic          ms_tick;
   logic [15:0]   sr_ms, dht_ms, tmo, tmo_lim;
   logic          sr_hit, dht_hit, sr_pend, dht_pend, rr_dht;
   logic          tmo_end, sr_err_ev, dht_err_ev;

   assign ms_tick = (pre == PW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || ms_tick) pre <= '0;
      else                pre <= pre + 1'b1;
   end

   assign sr_hit  = enable && ms_tick && (sr_ms == 16'(SR04_PERIOD_MS - 1));
   assign dht_hit = enable && ms_tick && (dht_ms == 16'(DHT_PERIOD_MS - 1));

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         sr_ms  <= '0;
         dht_ms <= '0;
      end else if (ms_tick) begin
         sr_ms  <= sr_hit  ? '0 : sr_ms + 1'b1;
         dht_ms <= dht_hit ? '0 : dht_ms + 1'b1;
      end
   end

   // a new request in the START cycle re-arms the flag (set beats clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_pend  <= 1'b0;
         dht_pend <= 1'b0;
      end else begin
         sr_pend  <= sr_hit || btn_req || (sr_pend && cur != SR04_START);
         dht_pend <= dht_hit || btn_req || (dht_pend && cur != DHT_START);
      end
   end

   assign tmo_lim    = (cur == SR04_WAIT) ? 16'(SR04_TMO_MS - 1)
                                          : 16'(DHT_TMO_MS - 1);
   assign tmo_end    = ms_tick && (tmo == tmo_lim);
   assign sr_err_ev  = (cur == SR04_WAIT) && !sr04_done && tmo_end;
   assign dht_err_ev = (cur == DHT_WAIT) &&
                       (dht_done ? !dht_valid : tmo_end);

   always_ff @(posedge clk) begin
      if (rst) cur <= IDLE;
      else     cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      unique case (cur)
         IDLE: begin
            if (sr_pend && !(dht_pend && rr_dht)) nxt = SR04_START;
            else if (dht_pend)                    nxt = DHT_START;
         end
         SR04_START: nxt = SR04_WAIT;
         SR04_WAIT:  if (sr04_done || tmo_end) nxt = IDLE;
         DHT_START:  nxt = DHT_WAIT;
         DHT_WAIT:   if (dht_done || tmo_end) nxt = IDLE;
         default:    nxt = IDLE;
      endcase
   end

   assign sr04_start = (cur == SR04_START);
   assign dht_start  = (cur == DHT_START);
   assign busy       = (cur != IDLE);
   assign state      = cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo      <= '0;
         rr_dht   <= 1'b0;
         dist_q   <= '0;
         hum_q    <= '0;
         temp_q   <= '0;
         err_sr04 <= 1'b0;
         err_dht  <= 1'b0;
      end else begin
         unique case (cur)
            SR04_START: begin
               tmo    <= '0;
               rr_dht <= 1'b1;
            end
            DHT_START: begin
               tmo    <= '0;
               rr_dht <= 1'b0;
            end
            SR04_WAIT: begin
               if (sr04_done) begin
                  dist_q   <= sr04_dist;
                  err_sr04 <= 1'b0;
               end
               if (sr_err_ev) err_sr04 <= 1'b1;
               if (ms_tick)   tmo <= tmo + 1'b1;
            end
            DHT_WAIT: begin
               if (dht_done && dht_valid) begin
                  hum_q   <= dht_hum;
                  temp_q  <= dht_temp;
                  err_dht <= 1'b0;
               end
               if (dht_err_ev) err_dht <= 1'b1;
               if (ms_tick)    tmo <= tmo + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SCHED_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_sr04 <= '0;
         err_cnt_dht  <= '0;
      end else begin
         if (sr_err_ev && err_cnt_sr04 != 8'hFF)
            err_cnt_sr04 <= err_cnt_sr04 + 1'b1;
         if (dht_err_ev && err_cnt_dht != 8'hFF)
            err_cnt_dht <= err_cnt_dht + 1'b1;
      end
   end
`endif

endmodule
